// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: parses the SPI byte stream into LED, burst-write and burst-read
// commands over a 16 x 8 register file; drives send_data with status or read data.
module spi_cmd_ctrl #(
    parameter int          NREGS     = 16,
    parameter logic [3:0]  STATUS_ID = 4'hA
) (
    input  logic                 ext_clk,
    input  logic                 rst,
    input  logic [7:0]           recv_data,
    input  logic                 recv_ready,
    input  logic                 send_ready,
    input  logic                 ss_n,
    output logic [7:0]           send_data,
    output logic                 led,
    output logic [8*NREGS-1:0]   cfg_regs,
    output logic                 err,
    output logic                 busy
);
    typedef enum logic [2:0] {IDLE, W_LEN, W_DATA, R_LEN, R_DATA} state_t;

    state_t                       state_q, state_d;
    logic [2:0]                   ss_q;
    logic [4:0]                   cnt_q, cnt_d, len;
    logic [3:0]                   addr_q, addr_d, addr_nx;
    logic                         led_q, led_d, err_q, err_d;
    logic [NREGS-1:0][7:0]        regs_q, regs_d;
    logic [7:0]                   send_q, send_d, status_d;
    logic                         frame_end;

    // ss_q[1] is the synchronized chip select, ss_q[2] its previous value
    assign frame_end = ss_q[1] & ~ss_q[2];
    assign len       = (recv_data[3:0] == 4'd0) ? 5'd16 : {1'b0, recv_data[3:0]};
    assign addr_nx   = addr_q + 4'd1;

    always_ff @(posedge ext_clk) begin
        if (rst) begin
            state_q <= IDLE;
            ss_q    <= 3'b111;
            cnt_q   <= '0;
            addr_q  <= '0;
            led_q   <= 1'b0;
            err_q   <= 1'b0;
            regs_q  <= '0;
            send_q  <= {STATUS_ID, 4'b0000};
        end else begin
            state_q <= state_d;
            ss_q    <= {ss_q[1:0], ss_n};
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            led_q   <= led_d;
            err_q   <= err_d;
            regs_q  <= regs_d;
            send_q  <= send_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (recv_ready) state_d = (recv_data[7:4] == 4'h4) ? W_LEN :
                                               (recv_data[7:4] == 4'h8) ? R_LEN : IDLE;
            W_LEN:   if (recv_ready) state_d = W_DATA;
            W_DATA:  if (recv_ready && cnt_q == 5'd1) state_d = IDLE;
            R_LEN:   if (recv_ready) state_d = R_DATA;
            R_DATA:  if (send_ready && cnt_q <= 5'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // frame end aborts whatever transition the byte requested
        if (frame_end) state_d = IDLE;
    end

    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        led_d  = led_q;
        err_d  = err_q;
        regs_d = regs_q;
        if (recv_ready) begin
            case (state_q)
                IDLE: begin
                    if (recv_data[7:4] == 4'h4 || recv_data[7:4] == 4'h8) begin
                        addr_d = recv_data[3:0];
                    end else if (recv_data <= 8'h04) begin
                        led_d = (recv_data == 8'h01) ? 1'b1 :
                                (recv_data == 8'h02) ? 1'b0 :
                                (recv_data == 8'h03) ? ~led_q : led_q;
                        err_d = (recv_data == 8'h04) ? 1'b0 : err_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                W_LEN, R_LEN: cnt_d = len;
                W_DATA: begin
                    regs_d[addr_q] = recv_data;
                    addr_d         = addr_nx;
                    cnt_d          = cnt_q - 5'd1;
                end
                default: ;
            endcase
        end
        if (state_q == R_DATA && send_ready) begin
            cnt_d  = cnt_q - 5'd1;
            addr_d = addr_nx;
        end
    end

    always_comb begin
        status_d = {STATUS_ID, 1'b0, err_d, state_d != IDLE, led_d};
        send_d   = (state_d != R_LEN && state_d != R_DATA)         ? status_d :
                   (state_q == R_LEN && state_d == R_DATA)         ? regs_q[addr_q] :
                   (state_q == R_DATA && send_ready)               ? regs_q[addr_nx] : send_q;
    end

    assign send_data = send_q;
    assign led       = led_q;
    assign err       = err_q;
    assign busy      = state_q != IDLE;
    assign cfg_regs  = regs_q;
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: directed and random byte/send_ready/frame-end stimulus, with a
// queue-based scoreboard checked against a command-level reference model.
module tb_spi_cmd_ctrl;
    logic         ext_clk = 1'b0;
    logic         rst, recv_ready, send_ready, ss_n, chk;
    logic [7:0]   recv_data, send_data;
    logic         led, err, busy;
    logic [127:0] cfg_regs;

    spi_cmd_ctrl dut (
        .ext_clk(ext_clk), .rst(rst), .recv_data(recv_data), .recv_ready(recv_ready),
        .send_ready(send_ready), .ss_n(ss_n), .send_data(send_data), .led(led),
        .cfg_regs(cfg_regs), .err(err), .busy(busy)
    );

    always #5 ext_clk = ~ext_clk;

    typedef struct packed {
        logic [7:0]   s;
        logic         l, e, b;
        logic [127:0] r;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;

    // reference model: mode 0 idle, 1 await write length, 2 writing, 3 await read length, 4 reading
    int         m_mode, m_rem;
    logic       m_led, m_err;
    logic [3:0] m_addr;
    logic [7:0] m_send;
    logic [7:0] mem [16];

    function automatic logic [7:0] status();
        return {4'hA, 1'b0, m_err, m_mode != 0, m_led};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_rem = 0; m_led = 0; m_err = 0; m_addr = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        m_send = 8'hA0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (m_mode)
            0: if (b[7:4] == 4'h4) begin m_addr = b[3:0]; m_mode = 1; end
               else if (b[7:4] == 4'h8) begin m_addr = b[3:0]; m_mode = 3; end
               else if (b == 8'h01) m_led = 1;
               else if (b == 8'h02) m_led = 0;
               else if (b == 8'h03) m_led = !m_led;
               else if (b == 8'h04) m_err = 0;
               else if (b != 8'h00) m_err = 1;
            1: begin m_rem = (b[3:0] == 0) ? 16 : int'(b[3:0]); m_mode = 2; end
            2: begin mem[m_addr] = b; m_addr++; m_rem--; if (m_rem == 0) m_mode = 0; end
            3: begin m_rem = (b[3:0] == 0) ? 16 : int'(b[3:0]); m_mode = 4; m_send = mem[m_addr]; end
            default: ;
        endcase
        if (m_mode < 3) m_send = status();
    endtask

    task automatic model_sready();
        if (m_mode == 4) begin
            m_addr++;
            m_rem--;
            if (m_rem > 0) m_send = mem[m_addr];
            else begin m_mode = 0; m_send = status(); end
        end
    endtask

    task automatic push();
        exp_t e;
        e.s = m_send; e.l = m_led; e.e = m_err; e.b = (m_mode != 0);
        for (int i = 0; i < 16; i++) e.r[8*i +: 8] = mem[i];
        q.push_back(e);
    endtask

    task automatic check(input string n, input logic [127:0] a, input logic [127:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, a, x, $time);
        end
    endtask

    // monitor: every edge that carries a byte, send_ready, reset or check request is compared
    initial begin
        exp_t e;
        forever begin
            @(posedge ext_clk);
            if (recv_ready || send_ready || rst || chk) begin
                @(negedge ext_clk);
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_underflow at %0t", $time);
                end else begin
                    e = q.pop_front();
                    check("send_data", 128'(send_data), 128'(e.s));
                    check("led", 128'(led), 128'(e.l));
                    check("err", 128'(err), 128'(e.e));
                    check("busy", 128'(busy), 128'(e.b));
                    check("cfg_regs", cfg_regs, e.r);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        model_byte(b); push();
        recv_data = b; recv_ready = 1;
        @(negedge ext_clk) recv_ready = 0;
        @(negedge ext_clk);
    endtask

    task automatic sready();
        model_sready(); push();
        send_ready = 1;
        @(negedge ext_clk) send_ready = 0;
        @(negedge ext_clk);
    endtask

    task automatic both(input logic [7:0] b);
        if (m_mode == 4) model_sready(); else model_byte(b);
        push();
        recv_data = b; recv_ready = 1; send_ready = 1;
        @(negedge ext_clk) begin recv_ready = 0; send_ready = 0; end
        @(negedge ext_clk);
    endtask

    task automatic frame_end();
        m_mode = 0; m_send = status(); push();
        ss_n = 1;
        repeat (3) @(negedge ext_clk);
        chk = 1;
        @(negedge ext_clk) begin chk = 0; ss_n = 0; end
        repeat (3) @(negedge ext_clk);
    endtask

    // byte lands on the very edge where the frame-end abort takes effect
    task automatic frame_byte(input logic [7:0] b);
        model_byte(b); m_mode = 0; m_send = status(); push();
        ss_n = 1;
        repeat (2) @(negedge ext_clk);
        recv_data = b; recv_ready = 1;
        @(negedge ext_clk) begin recv_ready = 0; ss_n = 0; end
        repeat (3) @(negedge ext_clk);
    endtask

    task automatic do_reset();
        model_reset(); push();
        rst = 1;
        @(negedge ext_clk) rst = 0;
        @(negedge ext_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        rst = 1; recv_ready = 0; send_ready = 0; ss_n = 0; chk = 0; recv_data = 0;
        model_reset(); push();
        @(negedge ext_clk) rst = 0;
        @(negedge ext_clk);
        foreach (b_list_a[i]) send_byte(b_list_a[i]);
        foreach (b_list_b[i]) send_byte(b_list_b[i]);
        foreach (b_list_c[i]) send_byte(b_list_c[i]);
        send_byte(8'h80); send_byte(8'h04);
        repeat (4) begin send_byte(8'h00); sready(); end
        send_byte(8'h8F); send_byte(8'h00);
        repeat (16) sready();
        send_byte(8'h42); send_byte(8'h04); send_byte(8'h77);
        frame_end();
        send_byte(8'h01);
        send_byte(8'h43); send_byte(8'h02); frame_byte(8'h01);
        send_byte(8'h03);
        repeat (300) begin
            case ($urandom_range(0, 3))
                0:       b = 8'($urandom);
                1:       b = 8'h40 | 8'($urandom_range(0, 15));
                2:       b = 8'h80 | 8'($urandom_range(0, 15));
                default: b = 8'($urandom_range(0, 4));
            endcase
            case ($urandom_range(0, 19))
                0,1,2,3,4,5,6,7,8,9: send_byte(b);
                10,11,12,13,14,15:   sready();
                16:                  frame_end();
                17:                  frame_byte(b);
                default:             both(b);
            endcase
        end
        frame_end();
        send_byte(8'h83); send_byte(8'h05); sready();
        do_reset();
        send_byte(8'h01);
        repeat (5) @(negedge ext_clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    logic [7:0] b_list_a [4] = '{8'h02, 8'h01, 8'hFF, 8'h03};
    logic [7:0] b_list_b [5] = '{8'h4E, 8'h03, 8'h11, 8'h22, 8'h33};
    logic [7:0] b_list_c [6] = '{8'h40, 8'h04, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
endmodule
